lsu_mem_port: RTL and testbench

- Load/store unit: the initiator for the single-port, word-wide data memory (reg_file_D-style port: Ad, Data, r, w, Out).
- Sits between the EX/MEM pipeline register and data memory.
- Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-granular memory cycles.
- Sub-word stores use read-modify-write. Loads are sign- or zero-extended.

---
 rtl/rv32_pkg.sv | 33 +++
 rtl/lsu_align.sv | 40 ++++
 rtl/lsu_mem_port.sv | 127 ++++++++++++
 tb/tb_lsu_mem_port.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I load/store definitions: funct3 width codes, LSU state encoding and request
// legality check.
package rv32_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StCapt,
    StWr,
    StFin
  } lsu_state_e;

  // 1 when the request must complete with err: bad funct3 for its direction, or misaligned.
  function automatic logic lsu_bad_req(input logic we, input logic [2:0] f3,
                                       input logic [1:0] off);
    logic legal;
    logic mis;
    if (we) begin
      legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end else begin
      legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
    end
    mis = ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
    return !legal || mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte/half lane steering: extracts and extends load data, and merges sub-word store data
// into a full memory word.
module lsu_align
  import rv32_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_val = {24'h0, byte_sel};
      F3_H:    load_val = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_val = {16'h0, half_sel};
      default: load_val = word;
    endcase

    store_word = word;
    case (funct3[1:0])
      2'b00: store_word[{offset, 3'b000} +: 8] = wdata[7:0];
      2'b01: begin
        if (offset[1]) store_word[31:16] = wdata[15:0];
        else           store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit driving a single-port word-wide data memory; sub-word stores are done as
// read-modify-write.
module lsu_mem_port
  import rv32_pkg::*;
#(
  parameter int unsigned AW   = 5,
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic            we,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  output logic            done,
  output logic            err,
  output logic            busy,
  output logic [AW-1:0]   mem_ad,
  output logic [XLEN-1:0] mem_data,
  output logic            mem_r,
  output logic            mem_w,
  input  logic [XLEN-1:0] mem_out
);

  lsu_state_e      state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic [AW-1:0]   word_q, word_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            we_q, we_d;
  logic            err_q, err_d;

  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] store_word;

  // Address bits above the word index are deliberately dropped so accesses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[XLEN-1:AW+2];

  lsu_align u_align (
    .funct3     (f3_q),
    .offset     (off_q),
    .word       (mem_out),
    .wdata      (data_q),
    .load_val   (load_val),
    .store_word (store_word)
  );

  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    off_d   = off_q;
    word_d  = word_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          f3_d   = funct3;
          off_d  = addr[1:0];
          word_d = addr[AW+1:2];
          data_d = wdata;
          we_d   = we;
          err_d  = lsu_bad_req(we, funct3, addr[1:0]);
          if (err_d)                      state_d = StFin;
          else if (we && funct3 == F3_W)  state_d = StWr;
          else                            state_d = StRd;
        end
      end
      StRd:   state_d = StCapt;
      StCapt: begin
        // data_q is reused to hold the merged word for the write-back half of RMW.
        if (we_q) begin
          data_d  = store_word;
          state_d = StWr;
        end else begin
          rdata_d = load_val;
          state_d = StFin;
        end
      end
      StWr:   state_d = StFin;
      StFin:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      f3_q    <= '0;
      off_q   <= '0;
      word_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      word_q  <= word_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  // Memory strobes decode straight from state so an asynchronous reset drops them at once.
  always_comb begin
    mem_r    = (state_q == StRd);
    mem_w    = (state_q == StWr);
    mem_ad   = (mem_r || mem_w) ? word_q : '0;
    mem_data = mem_w ? data_q : '0;
    done     = (state_q == StFin);
    err      = done && err_q;
    busy     = (state_q != StIdle) || req;
    rdata    = rdata_q;
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Randomized bench for lsu_mem_port: reference model with word memory and latency table,
// checked every cycle, plus literal directed cases.
module tb_lsu_mem_port;

  localparam int AW = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        busy;
  logic [AW-1:0] mem_ad;
  logic [31:0] mem_data;
  logic        mem_r;
  logic        mem_w;
  logic [31:0] mem_out;

  lsu_mem_port #(.AW(AW), .XLEN(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .we       (we),
    .funct3   (funct3),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .done     (done),
    .err      (err),
    .busy     (busy),
    .mem_ad   (mem_ad),
    .mem_data (mem_data),
    .mem_r    (mem_r),
    .mem_w    (mem_w),
    .mem_out  (mem_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Environment memory and the bench's own reference copy.
  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];

  always @(posedge clk) if (mem_r) mem_out <= mem[mem_ad];
  always @(negedge clk) if (mem_w) mem[mem_ad] <= mem_data;
  always @(posedge clk) cyc <= cyc + 1;

  // Expectation of the transaction in flight.
  int          t_r = -100;
  int          t_lat = 1;
  bit          t_err, t_rd, t_wr, t_load_ok;
  logic [4:0]  t_ad;
  logic [31:0] t_wdat;
  logic [31:0] rd_old = 0;
  logic [31:0] rd_new = 0;
  bit          chk_en = 0;
  int          last_lat = -1;
  int          nr = 0;
  int          nw = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) last_lat = cyc - t_r;
    if (mem_r) nr++;
    if (mem_w) nw++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int d;
      bit e_done, e_r, e_w, e_busy;
      logic [31:0] e_rdata;
      d       = cyc - t_r;
      e_done  = (d == t_lat);
      e_r     = t_rd && (d == 1);
      e_w     = t_wr && (d == t_lat - 1);
      e_busy  = req || (d >= 1 && d <= t_lat);
      e_rdata = (t_load_ok && d >= t_lat) ? rd_new : rd_old;
      chk("done", 32'(done), 32'(e_done));
      chk("err", 32'(err), 32'(e_done && t_err));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("mem_r", 32'(mem_r), 32'(e_r));
      chk("mem_w", 32'(mem_w), 32'(e_w));
      chk("mem_ad", 32'(mem_ad), (e_r || e_w) ? 32'(t_ad) : 32'h0);
      chk("mem_data", mem_data, e_w ? t_wdat : 32'h0);
      chk("rdata", rdata, e_rdata);
    end
  end

  // Reference: decide legality, latency, load result and new memory word from the ISA rules.
  task automatic model(input bit w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    logic [31:0] word, mask, val;
    int          sh;
    bit          legal, mis;
    legal = w ? (f3 <= 2) : (f3 != 3 && f3 <= 5);
    mis   = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
    if (t_load_ok) rd_old = rd_new;
    t_load_ok = 0;
    t_r   = cyc;
    t_err = !legal || mis;
    t_ad  = a[6:2];
    word  = ref_mem[t_ad];
    t_rd  = 0;
    t_wr  = 0;
    if (t_err) begin
      t_lat = 1;
    end else if (!w) begin
      t_lat = 3;
      t_rd  = 1;
      t_load_ok = 1;
      if (f3 == 0 || f3 == 4) begin
        sh  = int'(a[1:0]) * 8;
        val = (word >> sh) & 32'hff;
        if (f3 == 0 && val >= 128) val = val + 32'hFFFFFF00;
      end else if (f3 == 1 || f3 == 5) begin
        sh  = int'(a[1]) * 16;
        val = (word >> sh) & 32'hffff;
        if (f3 == 1 && val >= 32768) val = val + 32'hFFFF0000;
      end else begin
        val = word;
      end
      rd_new = val;
    end else begin
      t_wr = 1;
      if (f3 == 2) begin
        t_lat  = 2;
        t_wdat = wd;
      end else begin
        t_lat  = 4;
        t_rd   = 1;
        mask   = (f3 == 0) ? 32'hff : 32'hffff;
        sh     = (f3 == 0) ? int'(a[1:0]) * 8 : int'(a[1]) * 16;
        t_wdat = (word & ~(mask << sh)) | ((wd & mask) << sh);
      end
      ref_mem[t_ad] = t_wdat;
    end
    req    = 1;
    we     = w;
    funct3 = f3;
    addr   = a;
    wdata  = wd;
  endtask

  task automatic run(input bit w, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd);
    @(posedge clk); #1;
    model(w, f3, a, wd);
    @(posedge clk); #1;
    req    = 0;
    we     = 1'($urandom);
    funct3 = 3'($urandom);
    addr   = $urandom;
    wdata  = $urandom;
    repeat (t_lat) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] saved;
    reset = 0; req = 0; we = 0; funct3 = 0; addr = 0; wdata = 0;
    for (int i = 0; i < 32; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[3] = 32'h8899AABB; ref_mem[3] = 32'h8899AABB;
    mem[2] = 32'h11223344; ref_mem[2] = 32'h11223344;

    repeat (2) @(posedge clk);
    #1;
    chk("rst done", 32'(done), 0);
    chk("rst rdata", rdata, 0);
    chk("rst mem_r/w", 32'({mem_r, mem_w}), 0);
    chk("rst busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1;
    chk_en = 1;

    // LB / LHU / LH on 0x8899AABB
    run(0, 3'b000, 32'h0E, 0);
    chk("lb rdata", rdata, 32'hFFFFFF99);
    chk("lb latency", 32'(last_lat), 3);
    run(0, 3'b101, 32'h0E, 0);
    chk("lhu rdata", rdata, 32'h00008899);
    run(0, 3'b001, 32'h0C, 0);
    chk("lh rdata", rdata, 32'hFFFFAABB);

    // SB read-modify-write, then read back
    nr = 0; nw = 0;
    run(1, 3'b000, 32'h09, 32'hDEADBEEF);
    chk("sb reads", 32'(nr), 1);
    chk("sb writes", 32'(nw), 1);
    chk("sb latency", 32'(last_lat), 4);
    run(0, 3'b010, 32'h08, 0);
    chk("lw after sb", rdata, 32'h1122EF44);

    // SW, then misaligned LH
    nr = 0;
    run(1, 3'b010, 32'h10, 32'hCAFEF00D);
    chk("sw latency", 32'(last_lat), 2);
    chk("sw no read", 32'(nr), 0);
    chk("sw mem", mem[4], 32'hCAFEF00D);
    nr = 0; nw = 0;
    run(0, 3'b001, 32'h03, 0);
    chk("mis latency", 32'(last_lat), 1);
    chk("mis no access", 32'(nr + nw), 0);
    chk("mis rdata held", rdata, 32'h1122EF44);

    // SH with req held across two IDLE entries; 0x92 wraps onto word 4
    nr = 0; nw = 0;
    @(posedge clk); #1;
    model(1, 3'b001, 32'h92, 32'h12345678);
    repeat (t_lat + 1) @(posedge clk);
    #1;
    model(1, 3'b001, 32'h92, 32'h12345678);
    repeat (t_lat - 1) @(posedge clk);
    #1;
    req = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("sh held ops", 32'(nr * 16 + nw), 32'h22);
    chk("sh wrap mem", mem[4], 32'h5678F00D);

    // Reset during the write phase of an SB must abort the write
    saved = ref_mem[2];
    @(posedge clk); #1;
    model(1, 3'b000, 32'h0A, 32'h000000AA);
    @(posedge clk); #1;
    req = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre-reset mem_w", 32'(mem_w), 1);
    chk_en = 0;
    reset = 0;
    #1;
    chk("async mem_w", 32'(mem_w), 0);
    chk("async mem_ad", 32'(mem_ad), 0);
    chk("async mem_data", mem_data, 0);
    chk("async done/err", 32'({done, err}), 0);
    chk("async rdata", rdata, 0);
    ref_mem[2] = saved;
    rd_old = 0; rd_new = 0; t_load_ok = 0; t_r = -100; t_lat = 1;
    repeat (2) @(negedge clk);
    reset = 1;
    chk_en = 1;
    run(0, 3'b010, 32'h08, 0);
    chk("lw after abort", rdata, 32'h1122EF44);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      bit          w;
      logic [2:0]  f3;
      logic [31:0] a;
      w  = 1'($urandom);
      f3 = 3'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b10)      a[1:0] = 2'b00;
        else if (f3[1:0] == 2'b01) a[0] = 1'b0;
      end
      run(w, f3, a, $urandom);
    end

    for (int i = 0; i < 32; i++) chk("final mem", mem[i], ref_mem[i]);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
